// File: rtl/channel_counter_bank.sv
// rtl/channel_counter_bank.sv - bank of modulo-MOD channel counters with press edge detect and retriggerable alarm
// Optional down-count: define CCB_DOWN_EN to add the dir input (dir=1 decrements pressed channels).
module channel_counter_bank #(
    parameter int N_CH      = 10,
    parameter int CNT_W     = 4,
    parameter int MOD       = 10,
    parameter int INIT      = 1,
    parameter int IDX_W     = 4,
    parameter int ALARM_CYC = 50000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    preset,
    input  logic [IDX_W-1:0]        active_cnt,
    input  logic [N_CH-1:0]         btn,
    input  logic                    alarm_ack,
`ifdef CCB_DOWN_EN
    input  logic                    dir,
`endif
    output logic [N_CH*CNT_W-1:0]   status,
    output logic [IDX_W-1:0]        last_idx,
    output logic [N_CH-1:0]         wrap,
    output logic                    alarm,
    output logic [IDX_W-1:0]        alarm_idx
);
    localparam int               TMR_W    = (ALARM_CYC > 1) ? $clog2(ALARM_CYC) : 1;
    localparam logic [CNT_W-1:0] MAX_V    = CNT_W'(MOD - 1);
    localparam logic [CNT_W-1:0] INIT_V   = CNT_W'(INIT);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ALARM_CYC - 1);

    typedef enum logic {S_IDLE, S_ALARM} state_t;

    logic [CNT_W-1:0] r_cnt [N_CH];
    logic [N_CH-1:0]  r_btn_q;
    logic [N_CH-1:0]  r_wrap;
    logic [IDX_W-1:0] r_last_idx;
    logic [IDX_W-1:0] r_alarm_idx;
    state_t           r_state;
    logic [TMR_W-1:0] r_timer;

    logic             w_down;
    logic [N_CH-1:0]  w_press;
    logic [N_CH-1:0]  w_wrap_nxt;
    logic [CNT_W-1:0] w_cnt_nxt [N_CH];
    logic [IDX_W-1:0] w_press_idx;
    logic [IDX_W-1:0] w_wrap_idx;
    state_t           w_state_nxt;
    logic [TMR_W-1:0] w_timer_nxt;
    logic [IDX_W-1:0] w_alarm_idx_nxt;

`ifdef CCB_DOWN_EN
    assign w_down = dir;
`else
    assign w_down = 1'b0;
`endif

    // Descending scan so the last assignment leaves the lowest pressed index.
    always_comb begin
        w_press     = '0;
        w_wrap_nxt  = '0;
        w_press_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            w_cnt_nxt[i] = r_cnt[i];
            w_press[i]   = btn[i] & ~r_btn_q[i] & en & (IDX_W'(i) < active_cnt);
            if (w_press[i]) begin
                w_press_idx = IDX_W'(i);
                if (w_down) begin
                    if (r_cnt[i] == '0) begin
                        w_cnt_nxt[i]  = MAX_V;
                        w_wrap_nxt[i] = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
                    end
                end else begin
                    if (r_cnt[i] == MAX_V) begin
                        w_cnt_nxt[i]  = '0;
                        w_wrap_nxt[i] = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        w_wrap_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (r_wrap[i]) begin
                w_wrap_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= INIT_V;
            end
            r_btn_q    <= '0;
            r_wrap     <= '0;
            r_last_idx <= '0;
        end else begin
            r_btn_q <= btn;
            if (preset) begin
                for (int i = 0; i < N_CH; i++) begin
                    r_cnt[i] <= INIT_V;
                end
                r_wrap <= '0;
            end else begin
                for (int i = 0; i < N_CH; i++) begin
                    r_cnt[i] <= w_cnt_nxt[i];
                end
                r_wrap <= w_wrap_nxt;
                if (|w_press) begin
                    r_last_idx <= w_press_idx;
                end
            end
        end
    end

    // A wrap outranks acknowledge and timeout: it always (re)arms the full hold time.
    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_alarm_idx_nxt = r_alarm_idx;
        if (|r_wrap) begin
            w_state_nxt     = S_ALARM;
            w_timer_nxt     = TMR_LOAD;
            w_alarm_idx_nxt = w_wrap_idx;
        end else if (r_state == S_ALARM) begin
            if (alarm_ack || (r_timer == '0)) begin
                w_state_nxt = S_IDLE;
            end else begin
                w_timer_nxt = r_timer - TMR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_alarm_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_alarm_idx <= w_alarm_idx_nxt;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_status
        assign status[g*CNT_W +: CNT_W] = r_cnt[g];
    end

    assign last_idx  = r_last_idx;
    assign wrap      = r_wrap;
    assign alarm     = (r_state == S_ALARM);
    assign alarm_idx = r_alarm_idx;

endmodule

// File: tb/tb_channel_counter_bank.sv
// tb/tb_channel_counter_bank.sv - randomized self-checking bench for channel_counter_bank against a behavioural model
module tb_channel_counter_bank;
    localparam int N_CH      = 10;
    localparam int CNT_W     = 4;
    localparam int MOD       = 10;
    localparam int INIT      = 1;
    localparam int IDX_W     = 4;
    localparam int ALARM_CYC = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  en;
    logic                  preset;
    logic [IDX_W-1:0]      active_cnt;
    logic [N_CH-1:0]       btn;
    logic                  alarm_ack;
    logic                  dir;
    logic [N_CH*CNT_W-1:0] status;
    logic [IDX_W-1:0]      last_idx;
    logic [N_CH-1:0]       wrap;
    logic                  alarm;
    logic [IDX_W-1:0]      alarm_idx;

    int checks = 0;
    int errors = 0;

    channel_counter_bank #(
        .N_CH(N_CH), .CNT_W(CNT_W), .MOD(MOD), .INIT(INIT), .IDX_W(IDX_W), .ALARM_CYC(ALARM_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .preset(preset), .active_cnt(active_cnt),
        .btn(btn), .alarm_ack(alarm_ack),
`ifdef CCB_DOWN_EN
        .dir(dir),
`endif
        .status(status), .last_idx(last_idx), .wrap(wrap), .alarm(alarm), .alarm_idx(alarm_idx)
    );

    always #5 clk = ~clk;

    // Reference model: counter values as integers, alarm as "cycles of buzzer left".
    int        m_cnt [N_CH];
    bit [9:0]  m_bq;
    bit [9:0]  m_wrap;
    int        m_last;
    int        m_aidx;
    int        m_rem;

    function automatic logic [N_CH*CNT_W-1:0] m_status();
        logic [N_CH*CNT_W-1:0] r;
        for (int i = 0; i < N_CH; i++) r[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
        return r;
    endfunction

    function automatic void model_update();
        bit [9:0] nw;
        int       low;
        bit       down;
        nw   = '0;
        low  = -1;
        down = 1'b0;
`ifdef CCB_DOWN_EN
        down = dir;
`endif
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) m_cnt[i] = INIT;
            m_bq = '0; m_wrap = '0; m_last = 0; m_aidx = 0; m_rem = 0;
            return;
        end
        if (m_wrap != 0) begin
            m_rem = ALARM_CYC;
            for (int i = N_CH - 1; i >= 0; i--) if (m_wrap[i]) m_aidx = i;
        end else if (m_rem > 0) begin
            m_rem = alarm_ack ? 0 : m_rem - 1;
        end
        if (preset) begin
            for (int i = 0; i < N_CH; i++) m_cnt[i] = INIT;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (btn[i] && !m_bq[i] && en && (i < int'(active_cnt))) begin
                    if (low < 0) low = i;
                    if (down) begin
                        if (m_cnt[i] == 0) nw[i] = 1'b1;
                        m_cnt[i] = (m_cnt[i] + MOD - 1) % MOD;
                    end else begin
                        if (m_cnt[i] == MOD - 1) nw[i] = 1'b1;
                        m_cnt[i] = (m_cnt[i] + 1) % MOD;
                    end
                end
            end
            if (low >= 0) m_last = low;
        end
        m_wrap = nw;
        m_bq   = btn;
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        btn = '0; preset = 1'b0; alarm_ack = 1'b0; en = 1'b1; dir = 1'b0;
    endtask

    task automatic pulse(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            btn[ch] = 1'b1; step();
            btn[ch] = 1'b0; step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle_inputs(); active_cnt = '0;
        step(); step();
        checks++; if (status !== 40'h1111111111) begin errors++; $display("FAIL reset_status: got %h expected %h", status, 40'h1111111111); end
        checks++; if (alarm !== 1'b0 || wrap !== '0) begin errors++; $display("FAIL reset_alarm_wrap: got alarm=%b wrap=%b expected 0/0", alarm, wrap); end
        checks++; if (last_idx !== '0 || alarm_idx !== '0) begin errors++; $display("FAIL reset_idx: got last=%0d aidx=%0d expected 0/0", last_idx, alarm_idx); end
        rst_n = 1'b1; step();
    endtask

    task automatic test_active_window();
        int bad;
        active_cnt = 4'd3;
        pulse(2, 1);
        pulse(5, 1);
        checks++; if (status[2*CNT_W +: CNT_W] !== 4'd2) begin errors++; $display("FAIL win_ch2: got %0d expected 2", status[2*CNT_W +: CNT_W]); end
        checks++; if (status[5*CNT_W +: CNT_W] !== 4'd1) begin errors++; $display("FAIL win_ch5: got %0d expected 1", status[5*CNT_W +: CNT_W]); end
        checks++; if (last_idx !== 4'd2) begin errors++; $display("FAIL win_last: got %0d expected 2", last_idx); end
        bad = 0;
        btn[2] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (status !== m_status()) bad++;
        end
        btn[2] = 1'b0; step();
        checks++; if (status[2*CNT_W +: CNT_W] !== 4'd3 || bad != 0) begin errors++; $display("FAIL win_hold: got ch2=%0d mism=%0d expected 3/0", status[2*CNT_W +: CNT_W], bad); end
    endtask

    task automatic test_wrap_alarm();
        int bad, n;
        active_cnt = 4'd10;
        bad = 0;
        for (int k = 1; k <= 8; k++) begin
            btn[0] = 1'b1; step();
            if (status[CNT_W-1:0] !== CNT_W'((1 + k) % MOD) || wrap !== '0) bad++;
            btn[0] = 1'b0; step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_seq: got %0d bad steps expected 0", bad); end
        btn[0] = 1'b1; step();
        checks++; if (status[CNT_W-1:0] !== 4'd0 || wrap !== 10'b1 || alarm !== 1'b0) begin errors++; $display("FAIL wrap_ch0: got v=%0d wrap=%b alarm=%b expected 0/1/0", status[CNT_W-1:0], wrap, alarm); end
        btn[0] = 1'b0;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (k == 0 && (alarm_idx !== 4'd0 || wrap !== '0)) bad++;
            if (alarm) n++;
            if (alarm !== (m_rem > 0)) bad++;
        end
        checks++; if (n != ALARM_CYC || bad != 0) begin errors++; $display("FAIL alarm_len: got %0d cycles (%0d bad) expected %0d", n, bad, ALARM_CYC); end
    endtask

    task automatic test_retrigger();
        int n, bad;
        pulse(3, 8);
        pulse(4, 8);
        checks++; if (status[3*CNT_W +: CNT_W] !== 4'd9 || status[4*CNT_W +: CNT_W] !== 4'd9 || alarm !== 1'b0) begin errors++; $display("FAIL retrig_setup: got ch3=%0d ch4=%0d alarm=%b expected 9/9/0", status[3*CNT_W +: CNT_W], status[4*CNT_W +: CNT_W], alarm); end
        btn[3] = 1'b1; step();
        btn[3] = 1'b0;
        for (int k = 0; k < 4; k++) step();
        btn[4] = 1'b1; step();
        checks++; if (wrap !== 10'b1_0000 || alarm !== 1'b1) begin errors++; $display("FAIL retrig_wrap: got wrap=%b alarm=%b expected 0000010000/1", wrap, alarm); end
        btn[4] = 1'b0; alarm_ack = 1'b1; step();
        alarm_ack = 1'b0;
        checks++; if (alarm_idx !== 4'd4 || alarm !== 1'b1) begin errors++; $display("FAIL retrig_idx: got aidx=%0d alarm=%b expected 4/1", alarm_idx, alarm); end
        n = 0; bad = 0;
        for (int k = 0; k < 12; k++) begin
            if (alarm) n++;
            if (alarm !== (m_rem > 0) || alarm_idx !== 4'(m_aidx)) bad++;
            step();
        end
        checks++; if (n != ALARM_CYC || bad != 0) begin errors++; $display("FAIL retrig_len: got %0d cycles (%0d bad) expected %0d", n, bad, ALARM_CYC); end
    endtask

    task automatic test_ack();
        pulse(9, 8);
        btn[9] = 1'b1; step();
        btn[9] = 1'b0; step(); step();
        checks++; if (alarm !== 1'b1 || alarm_idx !== 4'd9) begin errors++; $display("FAIL ack_pre: got alarm=%b aidx=%0d expected 1/9", alarm, alarm_idx); end
        alarm_ack = 1'b1; step();
        alarm_ack = 1'b0;
        checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL ack_drop: got alarm=%b expected 0", alarm); end
    endtask

    task automatic test_simultaneous();
        active_cnt = 4'd10;
        btn = 10'b00_0000_1010; step();
        checks++; if (status[1*CNT_W +: CNT_W] !== 4'd2 || status[3*CNT_W +: CNT_W] !== 4'd1 || last_idx !== 4'd1) begin errors++; $display("FAIL simul_inc: got ch1=%0d ch3=%0d last=%0d expected 2/1/1", status[1*CNT_W +: CNT_W], status[3*CNT_W +: CNT_W], last_idx); end
        btn = '0; step();
        preset = 1'b1; btn = 10'b00_0000_1010; step();
        checks++; if (status !== 40'h1111111111 || wrap !== '0 || last_idx !== 4'd1) begin errors++; $display("FAIL simul_preset: got %h wrap=%b last=%0d expected 1111111111/0/1", status, wrap, last_idx); end
        preset = 1'b0; btn = '0; step();
    endtask

`ifdef CCB_DOWN_EN
    task automatic test_down();
        dir = 1'b1; active_cnt = 4'd10;
        pulse(7, 1);
        checks++; if (status[7*CNT_W +: CNT_W] !== 4'd0) begin errors++; $display("FAIL down_dec: got %0d expected 0", status[7*CNT_W +: CNT_W]); end
        btn[7] = 1'b1; step();
        checks++; if (status[7*CNT_W +: CNT_W] !== 4'd9 || wrap !== 10'b10_0000_0000 >> 2) begin errors++; $display("FAIL down_wrap: got v=%0d wrap=%b expected 9/0010000000", status[7*CNT_W +: CNT_W], wrap); end
        btn[7] = 1'b0; step();
        checks++; if (alarm !== 1'b1 || alarm_idx !== 4'd7) begin errors++; $display("FAIL down_alarm: got alarm=%b aidx=%0d expected 1/7", alarm, alarm_idx); end
        dir = 1'b0;
        for (int k = 0; k < 10; k++) step();
    endtask
`endif

    task automatic test_random();
        int bad;
        bad = 0;
        for (int k = 0; k < 600; k++) begin
            btn        = N_CH'($urandom);
            en         = ($urandom % 8) != 0;
            preset     = ($urandom % 20) == 0;
            active_cnt = IDX_W'($urandom % 16);
            alarm_ack  = ($urandom % 10) == 0;
            rst_n      = ($urandom % 80) != 0;
            dir        = 1'($urandom);
            step();
            checks++;
            if (status !== m_status() || wrap !== N_CH'(m_wrap) || last_idx !== IDX_W'(m_last) ||
                alarm !== (m_rem > 0) || alarm_idx !== IDX_W'(m_aidx)) begin
                errors++;
                if (bad < 5) $display("FAIL random[%0d]: got st=%h w=%b li=%0d al=%b ai=%0d expected st=%h w=%b li=%0d al=%b ai=%0d",
                    k, status, wrap, last_idx, alarm, alarm_idx, m_status(), m_wrap, m_last, m_rem > 0, m_aidx);
                bad++;
            end
        end
        rst_n = 1'b1; idle_inputs(); step();
    endtask

    initial begin
        for (int i = 0; i < N_CH; i++) m_cnt[i] = INIT;
        m_bq = '0; m_wrap = '0; m_last = 0; m_aidx = 0; m_rem = 0;
        rst_n = 1'b0; idle_inputs(); active_cnt = '0;
        @(negedge clk);
        test_reset();
        test_active_window();
        test_wrap_alarm();
        test_retrigger();
        test_ack();
        test_simultaneous();
`ifdef CCB_DOWN_EN
        test_down();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
